// File: rtl/qif_spike_isi_encoder.sv
// qif_spike_isi_encoder: turns rising edges of the QIF spike line into
// inter-spike-interval words, filtered by a refractory window and queued in a small FIFO.
module qif_spike_isi_encoder #(
    parameter int ISI_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REFRACT    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              spike_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ISI_W-1:0]                  out_isi,
    output logic                              out_sat,
    output logic                              out_first,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              drop
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = ISI_W + 2;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;
    localparam logic [ISI_W-1:0] REF_LIM = ISI_W'(REFRACT);
    localparam logic [CW-1:0]    FULL    = CW'(FIFO_DEPTH);

    logic             r_prev;
    logic             r_first_pend;
    logic             r_drop;
    logic [ISI_W-1:0] r_isi_cnt;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;
    logic [EW-1:0]    r_head;
    logic [EW-1:0]    r_mem [FIFO_DEPTH];

    logic             w_event;
    logic             w_accept;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [EW-1:0]    w_word;
    logic [CW-1:0]    w_cnt_pop;
    logic [CW-1:0]    w_cnt_next;
    logic [AW-1:0]    w_rd_next;

    always_comb begin
        w_event    = spike_in & ~r_prev;
        w_accept   = w_event & (r_first_pend | (r_isi_cnt > REF_LIM));
        w_full     = r_cnt == FULL;
        w_pop      = (r_cnt != '0) & out_ready;
        w_push     = w_accept & (~w_full | w_pop);
        w_word     = {r_first_pend, r_isi_cnt == ISI_MAX, r_isi_cnt};
        w_cnt_pop  = r_cnt - CW'(w_pop);
        w_cnt_next = w_cnt_pop + CW'(w_push);
        w_rd_next  = r_rd + AW'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev       <= 1'b0;
            r_first_pend <= 1'b1;
            r_drop       <= 1'b0;
            r_isi_cnt    <= '0;
            r_rd         <= '0;
            r_wr         <= '0;
            r_cnt        <= '0;
            r_head       <= '0;
        end else begin
            r_prev    <= spike_in;
            r_isi_cnt <= w_accept ? ISI_W'(1) :
                         (r_isi_cnt == ISI_MAX) ? r_isi_cnt : r_isi_cnt + ISI_W'(1);
            if (w_accept)
                r_first_pend <= 1'b0;
            if (w_accept & ~w_push)
                r_drop <= 1'b1;
            if (w_push)
                r_wr <= r_wr + AW'(1);
            r_rd  <= w_rd_next;
            r_cnt <= w_cnt_next;
            // Head register holds its value while empty; a word pushed into an
            // empty (or just-emptied) FIFO bypasses the array.
            if (w_cnt_next != '0)
                r_head <= (w_cnt_pop == '0) ? w_word : r_mem[w_rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= w_word;
    end

    assign out_valid  = r_cnt != '0;
    assign out_first  = r_head[EW-1];
    assign out_sat    = r_head[EW-2];
    assign out_isi    = r_head[ISI_W-1:0];
    assign fifo_count = r_cnt;
    assign drop       = r_drop;
endmodule
